// File: rtl/smem_result_writer.sv
// smem_result_writer: packs 256-bit SMEM results into 512-bit lines, buffers them and appends a batch terminator
module smem_result_writer #(
  parameter int DEPTH = 16,
  parameter int READ_NUM_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [8:0]                batch_size,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [READ_NUM_WIDTH-1:0] res_read_num,
  input  logic [63:0]               res_x0,
  input  logic [63:0]               res_x1,
  input  logic [63:0]               res_x2,
  input  logic [63:0]               res_info,
  input  logic                      read_finish,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [511:0]              wr_data,
  output logic                      batch_done
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {COLLECT, FLUSH, TERM, DONE} state_t;
  state_t state, state_nx;
  logic [511:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [255:0] staged, entry;
  logic half_full, half_clr, full, accept, pop, push;
  logic [31:0] result_cnt;
  logic [8:0] finish_cnt, finish_nx;
  logic [511:0] push_line;
  logic unused_info;
  assign unused_info = ^res_info[63:56];
  assign full = count == (AW+1)'(DEPTH);
  assign res_ready = reset_n && state == COLLECT && !full;
  assign accept = res_valid && res_ready;
  assign wr_valid = count != '0;
  assign pop = wr_valid && wr_ready;
  assign wr_data = wr_valid ? mem[rp] : '0;
  assign batch_done = state == DONE && !wr_valid;
  assign entry = {8'(res_read_num), res_info[55:0], res_x2, res_x1, res_x0};
  assign finish_nx = finish_cnt + 9'(read_finish);
  // next state and line-push selection
  always_comb begin
    state_nx = state;
    push = 1'b0;
    half_clr = 1'b0;
    push_line = {entry, staged};
    case (state)
      COLLECT: begin
        push = accept && half_full;
        if (read_finish && finish_nx == batch_size && batch_size != '0) state_nx = FLUSH;
      end
      FLUSH: begin
        if (!half_full) state_nx = TERM;
        else if (!full) begin
          push = 1'b1;
          push_line = {{256{1'b1}}, staged};
          half_clr = 1'b1;
          state_nx = TERM;
        end
      end
      TERM: begin
        push_line = {64'hFFFF_FFFF_FFFF_FFFF, 416'd0, result_cnt};
        if (!full) begin
          push = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = DONE;
    endcase
  end
  // FIFO storage, written only when a push is allowed
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= push_line;
  end
  // state, staging, counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= COLLECT;
      wp <= '0;
      rp <= '0;
      count <= '0;
      half_full <= 1'b0;
      staged <= '0;
      result_cnt <= '0;
      finish_cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (accept) begin
        result_cnt <= result_cnt + 1;
        half_full <= !half_full;
        if (!half_full) staged <= entry;
      end
      if (half_clr) half_full <= 1'b0;
      if (state == COLLECT) finish_cnt <= finish_nx;
    end
  end
endmodule

// File: tb/tb_smem_result_writer.sv
// tb_smem_result_writer: directed and randomized checks against a line-queue reference model
module tb_smem_result_writer;
  localparam int DEPTH = 16;
  logic clk = 0, reset_n = 0, res_valid = 0, read_finish = 0, wr_ready = 0;
  logic res_ready, wr_valid, batch_done;
  logic [8:0] batch_size = 0;
  logic [7:0] res_read_num = 0;
  logic [63:0] res_x0 = 0, res_x1 = 0, res_x2 = 0, res_info = 0;
  logic [511:0] wr_data;
  int checks = 0, errors = 0;
  logic [511:0] exp_q[$];
  logic [255:0] staged;
  bit staged_v = 0, collecting = 1;
  int unsigned rcnt = 0;
  int fin = 0;

  smem_result_writer #(.DEPTH(DEPTH), .READ_NUM_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .batch_size(batch_size), .res_valid(res_valid),
    .res_ready(res_ready), .res_read_num(res_read_num), .res_x0(res_x0), .res_x1(res_x1),
    .res_x2(res_x2), .res_info(res_info), .read_finish(read_finish), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .batch_done(batch_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [255:0] cur_entry();
    return {res_read_num, res_info[55:0], res_x2, res_x1, res_x0};
  endfunction

  function automatic logic [511:0] term_line(input int unsigned n);
    logic [511:0] t;
    t = '0;
    t[511:448] = '1;
    t[31:0] = n;
    return t;
  endfunction

  task automatic rand_entry();
    res_read_num = 8'($urandom_range(0, 254));
    res_x0 = {$urandom, $urandom};
    res_x1 = {$urandom, $urandom};
    res_x2 = {$urandom, $urandom};
    res_info = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    exp_q.delete();
    staged_v = 0;
    collecting = 1;
    rcnt = 0;
    fin = 0;
  endtask

  // sample at negedge, update the model for the coming edge, advance one cycle
  task automatic cycle();
    bit rdy;
    logic [255:0] e;
    rdy = collecting && exp_q.size() < DEPTH;
    chk("res_ready", res_ready, rdy);
    if (collecting) begin
      chk("wr_valid", wr_valid, exp_q.size() != 0);
      chk("batch_done_low", batch_done, 0);
    end
    if (wr_valid) begin
      if (exp_q.size() == 0) chk("unexpected_line", wr_valid, 0);
      else begin
        chk("wr_data", wr_data, exp_q[0]);
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
    if (res_valid && rdy) begin
      e = cur_entry();
      rcnt++;
      if (staged_v) begin
        exp_q.push_back({e, staged});
        staged_v = 0;
      end else begin
        staged = e;
        staged_v = 1;
      end
    end
    if (collecting && read_finish) begin
      fin++;
      if (fin == int'(batch_size) && batch_size != 0) begin
        collecting = 0;
        if (staged_v) begin
          exp_q.push_back({{256{1'b1}}, staged});
          staged_v = 0;
        end
        exp_q.push_back(term_line(rcnt));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0;
    res_valid = 0;
    read_finish = 0;
    wr_ready = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_batch_done", batch_done, 0);
    chk("rst_res_ready", res_ready, 0);
    model_reset();
    reset_n = 1;
    #1 chk("ready_after_reset", res_ready, 1);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    res_valid = 0;
    read_finish = 0;
    wr_ready = 1;
    while (!(batch_done && exp_q.size() == 0) && n < bound) begin
      cycle();
      n++;
    end
    chk("batch_done", batch_done, 1);
    chk("drained", exp_q.size(), 0);
    repeat (3) cycle();
    chk("batch_done_sticky", batch_done, 1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // two-entry pack
    batch_size = 2;
    wr_ready = 1;
    rand_entry();
    res_read_num = 3;
    res_x0 = 1;
    res_valid = 1;
    cycle();
    rand_entry();
    res_read_num = 4;
    res_x0 = 2;
    cycle();
    res_valid = 0;
    chk("pack_valid", wr_valid, 1);
    chk("pack_x0_a", wr_data[63:0], 1);
    chk("pack_rn_a", wr_data[255:248], 3);
    chk("pack_x0_b", wr_data[319:256], 2);
    chk("pack_rn_b", wr_data[511:504], 4);
    read_finish = 1;
    cycle();
    cycle();
    wait_done(100);
    // odd count flush
    do_reset();
    batch_size = 1;
    wr_ready = 1;
    rand_entry();
    res_valid = 1;
    cycle();
    res_valid = 0;
    read_finish = 1;
    cycle();
    wait_done(100);
    // backpressure with a batch that never completes
    do_reset();
    batch_size = 0;
    wr_ready = 0;
    for (int i = 0; i < 4 * DEPTH && rcnt < 2 * DEPTH; i++) begin
      rand_entry();
      res_valid = 1;
      cycle();
    end
    repeat (3) begin
      rand_entry();
      cycle();
    end
    chk("full_lines", exp_q.size(), DEPTH);
    chk("full_ready", res_ready, 0);
    res_valid = 0;
    wr_ready = 1;
    read_finish = 1;
    cycle();
    read_finish = 0;
    repeat (DEPTH + 3) cycle();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_still_collect", res_ready, 1);
    // final read_finish together with the second entry
    do_reset();
    batch_size = 2;
    wr_ready = 1;
    rand_entry();
    res_valid = 1;
    read_finish = 1;
    cycle();
    rand_entry();
    cycle();
    wait_done(100);
    // mid-batch reset discards buffered data
    do_reset();
    batch_size = 10;
    wr_ready = 0;
    res_valid = 1;
    repeat (3) begin
      rand_entry();
      cycle();
    end
    res_valid = 0;
    cycle();
    chk("mid_line_buffered", wr_valid, 1);
    do_reset();
    batch_size = 1;
    rand_entry();
    res_valid = 1;
    cycle();
    res_valid = 0;
    read_finish = 1;
    cycle();
    wait_done(100);
    // randomized batches
    for (int b = 0; b < 4; b++) begin
      do_reset();
      batch_size = 9'($urandom_range(1, 20));
      for (int i = 0; i < 300 && collecting; i++) begin
        rand_entry();
        res_valid = ($urandom_range(0, 2) != 0);
        wr_ready = ($urandom_range(0, 3) != 0);
        read_finish = ($urandom_range(0, 6) == 0);
        cycle();
      end
      res_valid = 0;
      for (int i = 0; i < 40 && collecting; i++) begin
        read_finish = 1;
        cycle();
      end
      wait_done(400);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/smem_result_writer.md
Name: smem_result_writer

Overview:
- Output-side counterpart of the read loader: collects SMEM results from the backward pipeline and packs two 256-bit entries per 512-bit cache line.
- Buffers lines in an internal FIFO and drains them to the host write channel with a valid/ready handshake.
- At batch end, flushes any half-filled line, then appends a terminator line and signals completion.

Parameters:
- DEPTH, 16, number of 512-bit lines in the output FIFO (power of two, >=2)
- READ_NUM_WIDTH, 8, width of the read number field

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- batch_size  input  9  number of reads in the batch; stable while running
- res_valid  input  1  result entry offered
- res_ready  output  1  writer can accept an entry this cycle
- res_read_num  input  READ_NUM_WIDTH  read the result belongs to
- res_x0  input  64  SMEM interval x0
- res_x1  input  64  SMEM interval x1
- res_x2  input  64  SMEM interval x2
- res_info  input  64  SMEM info; only bits [55:0] are kept
- read_finish  input  1  one-cycle pulse: one read has retired from the pipeline
- wr_valid  output  1  output line available
- wr_ready  input  1  host consumer takes the line
- wr_data  output  512  output line
- batch_done  output  1  sticky completion flag

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFO emptied, staging cleared, counters zeroed, state COLLECT.
  - Outputs: res_ready=0 during reset; wr_valid=0; wr_data=0; batch_done=0.
  - Reset mid-batch discards all buffered data.
- Entry format (256 bits):
  - [63:0]=x0, [127:64]=x1, [191:128]=x2.
  - [247:192]=info[55:0]; [255:248]=read_num.
- Pad entry: 256 bits of all ones (read_num field 8'hFF marks it invalid).
- Accept rule:
  - An entry is accepted when res_valid && res_ready at a clk edge.
  - res_ready = (state==COLLECT) && (fifo_count < DEPTH), registered-count based.
- Packing:
  - First accepted entry goes to the staging register; half_full=1.
  - The second accepted entry pushes line {entry2, staged} into the FIFO (entry2 in [511:256]) at the same edge; half_full=0.
  - Entries are never reordered.
- result_cnt (32-bit) increments on every accepted entry and wraps naturally.
- FIFO:
  - A line pushed at edge k makes wr_valid=1 in the cycle after edge k.
  - wr_data = head line, held stable while wr_valid && !wr_ready.
  - A pop occurs on wr_valid && wr_ready.
  - A push is blocked when fifo_count==DEPTH, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves the count unchanged.
  - wr_data=0 when the FIFO is empty.
- finish_cnt (9-bit) increments on read_finish.
- State machine:
  - COLLECT -> FLUSH when the updated finish_cnt equals batch_size and batch_size != 0.
  - An entry accepted in the same cycle as the final read_finish is included in the batch.
  - FLUSH: if half_full, push {pad, staged} when not full, clear half_full, then go to TERM. If not half_full, go to TERM next cycle.
  - TERM: push the terminator line when not full, then go to DONE. Terminator = [511:448]=64'hFFFF_FFFF_FFFF_FFFF, [31:0]=result_cnt, all other bits 0.
  - DONE: batch_done=1 once the FIFO is empty; it stays 1 until reset. res_ready stays 0.
- read_finish pulses outside COLLECT are ignored.
- batch_size==0: the block never leaves COLLECT.

Test Plan:
- Reset check: reset_n=0 for 2 cycles -> wr_valid=0, wr_data=0, batch_done=0, res_ready=0. After release -> res_ready=1.
- Two-entry pack: entry A (read 3, x0=1) then entry B (read 4, x0=2), wr_ready=1.
  - One line appears the cycle after B is accepted.
  - wr_data[63:0]=1, [255:248]=3, [319:256]=2, [511:504]=4.
- Odd count flush: batch_size=1, one entry, then read_finish.
  - Line 1 = {all-ones, entry}.
  - Line 2 = terminator with [31:0]=1.
  - batch_done rises after both lines drain.
- Backpressure: wr_ready=0, push 2*DEPTH entries.
  - res_ready drops after DEPTH lines.
  - wr_data stays stable with no loss.
  - Then wr_ready=1 -> all lines exit in order.
- Simultaneous event: final read_finish in the same cycle as an accepted second entry -> full line, then terminator with count=2, no pad line.
- Mid-batch reset: 3 entries accepted, reset_n pulsed -> FIFO empty, wr_valid=0, result_cnt restarts at 0.
